// File: rtl/mesi_pkg.sv
// mesi_pkg: shared MESI, opcode, bus and FSM types for the line controller
package mesi_pkg;
   localparam int ADDR_W_DEF   = 32;
   localparam int INDEX_W_DEF  = 4;
   localparam int OFFSET_W_DEF = 6;
   typedef enum logic [1:0] {ST_I, ST_S, ST_E, ST_M} mesi_t;
   typedef enum logic [3:0] {
      OP_RD, OP_WR, OP_IFETCH, OP_L2_INV, OP_SNP_INV,
      OP_SNP_RD, OP_SNP_WR, OP_SNP_RWIM, OP_CLEAR, OP_PRINT
   } op_t;
   typedef enum logic [1:0] {BUS_READ, BUS_WRITE, BUS_INV, BUS_RWIM} bus_op_t;
   typedef enum logic [1:0] {SNP_NOHIT, SNP_HIT, SNP_HITM} snoop_t;
   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_WB, S_FILL, S_BUSOP, S_UPDATE, S_CLEAR
   } fsm_t;
endpackage

// File: rtl/mesi_state_array.sv
// mesi_state_array: direct-mapped tag/state store, async read, single sync write
module mesi_state_array
   import mesi_pkg::*;
#(
   parameter int INDEX_W = INDEX_W_DEF,
   parameter int TAG_W   = 22
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [INDEX_W-1:0] rd_index,
   output logic [TAG_W-1:0]   rd_tag,
   output mesi_t              rd_state,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  mesi_t              wr_state
);
   logic [TAG_W-1:0] tags   [2**INDEX_W];
   mesi_t            states [2**INDEX_W];
   assign rd_tag   = tags[rd_index];
   assign rd_state = states[rd_index];
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2**INDEX_W; i++) begin
            tags[i]   <= '0;
            states[i] <= ST_I;
         end
      end else if (wr_en) begin
         tags[wr_index]   <= wr_tag;
         states[wr_index] <= wr_state;
      end
   end
endmodule

// File: rtl/mesi_line_ctrl.sv
// mesi_line_ctrl: per-line MESI controller issuing bus ops and publishing state updates
module mesi_line_ctrl
   import mesi_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int INDEX_W  = INDEX_W_DEF,
   parameter int OFFSET_W = OFFSET_W_DEF
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [3:0]         cmd_op,
   input  logic [ADDR_W-1:0]  cmd_addr,
   output logic               bus_valid,
   output logic [1:0]         bus_op,
   output logic [ADDR_W-1:0]  bus_addr,
   input  logic               bus_ack,
   input  logic [1:0]         bus_snoop_res,
   output logic               upd_valid,
   output logic [INDEX_W-1:0] upd_index,
   output logic [1:0]         upd_state,
   output logic [1:0]         snoop_res_o
);
   localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINE_W = ADDR_W - OFFSET_W;
   fsm_t               st, lk_next;
   logic [3:0]         op_q;
   logic [LINE_W-1:0]  line_q;
   logic [INDEX_W-1:0] idx, clr_idx, wr_idx;
   logic [TAG_W-1:0]   ctag, rd_tag, tag_q, wr_tag;
   logic [ADDR_W-1:0]  line_addr, lk_addr;
   mesi_t              rd_state, fin_q, wr_state, fill_state, lk_fin, new_fin;
   snoop_t             snp_q, lk_snp, new_snp;
   bus_op_t            lk_op;
   logic               hit, evict, wr_en, to_upd;

   assign idx        = line_q[INDEX_W-1:0];
   assign ctag       = line_q[LINE_W-1:INDEX_W];
   assign line_addr  = {line_q, {OFFSET_W{1'b0}}};
   assign hit        = rd_tag == ctag && rd_state != ST_I;
   assign evict      = op_q == OP_RD || op_q == OP_WR || op_q == OP_IFETCH;
   assign fill_state = op_q == OP_WR ? ST_M : bus_snoop_res == SNP_NOHIT ? ST_E : ST_S;
   assign cmd_ready  = st == S_IDLE;

   always_comb begin
      lk_next = S_UPDATE;
      lk_op   = BUS_WRITE;
      lk_addr = line_addr;
      lk_fin  = rd_state;
      lk_snp  = SNP_NOHIT;
      case (op_q)
         OP_RD, OP_IFETCH, OP_WR: begin
            if (op_q == OP_WR) lk_fin = ST_M;
            if (!hit) begin
               lk_next = rd_state == ST_M ? S_WB : S_FILL;
               lk_op   = rd_state == ST_M ? BUS_WRITE : op_q == OP_WR ? BUS_RWIM : BUS_READ;
               lk_addr = rd_state == ST_M ? {rd_tag, idx, {OFFSET_W{1'b0}}} : line_addr;
            end else if (op_q == OP_WR && rd_state == ST_S) begin
               lk_next = S_BUSOP;
               lk_op   = BUS_INV;
            end
         end
         OP_L2_INV: if (hit) begin
            lk_fin  = ST_I;
            lk_next = rd_state == ST_M ? S_WB : S_UPDATE;
         end
         OP_SNP_INV: if (hit && rd_state == ST_S) lk_fin = ST_I;
         OP_SNP_RD, OP_SNP_RWIM: if (hit) begin
            lk_fin  = op_q == OP_SNP_RD ? ST_S : ST_I;
            lk_snp  = rd_state == ST_M ? SNP_HITM : SNP_HIT;
            lk_next = rd_state == ST_M ? S_WB : S_UPDATE;
         end
         default: ;
      endcase
   end

   // a snoop/L2 writeback finishes the command; an eviction writeback continues into the fill
   assign to_upd  = st == S_LOOKUP ? lk_next == S_UPDATE
                  : bus_ack && (st == S_FILL || st == S_BUSOP || (st == S_WB && !evict));
   assign new_fin = st == S_LOOKUP ? lk_fin : st == S_FILL ? fill_state : fin_q;
   assign new_snp = st == S_LOOKUP ? lk_snp : snp_q;

   assign wr_en    = st == S_UPDATE || st == S_CLEAR || (st == S_FILL && bus_ack);
   assign wr_idx   = st == S_CLEAR ? clr_idx : idx;
   assign wr_tag   = st == S_CLEAR ? '0 : st == S_FILL ? ctag : tag_q;
   assign wr_state = st == S_CLEAR ? ST_I : st == S_FILL ? fill_state : fin_q;

   mesi_state_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
      .clk      (clk),
      .reset    (reset),
      .rd_index (idx),
      .rd_tag   (rd_tag),
      .rd_state (rd_state),
      .wr_en    (wr_en),
      .wr_index (wr_idx),
      .wr_tag   (wr_tag),
      .wr_state (wr_state)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         st          <= S_IDLE;
         op_q        <= '0;
         line_q      <= '0;
         clr_idx     <= '0;
         tag_q       <= '0;
         fin_q       <= ST_I;
         snp_q       <= SNP_NOHIT;
         bus_valid   <= 1'b0;
         bus_op      <= '0;
         bus_addr    <= '0;
         upd_valid   <= 1'b0;
         upd_index   <= '0;
         upd_state   <= '0;
         snoop_res_o <= '0;
      end else begin
         upd_valid   <= to_upd;
         snoop_res_o <= to_upd ? new_snp : SNP_NOHIT;
         if (to_upd) begin
            upd_index <= idx;
            upd_state <= new_fin;
         end
         case (st)
            S_IDLE: if (cmd_valid) begin
               op_q    <= cmd_op;
               line_q  <= cmd_addr[ADDR_W-1:OFFSET_W];
               clr_idx <= '0;
               st      <= cmd_op == OP_CLEAR ? S_CLEAR : cmd_op <= OP_SNP_RWIM ? S_LOOKUP : S_IDLE;
            end
            S_LOOKUP: begin
               st        <= lk_next;
               fin_q     <= lk_fin;
               tag_q     <= rd_tag;
               snp_q     <= lk_snp;
               bus_valid <= lk_next != S_UPDATE;
               bus_op    <= lk_op;
               bus_addr  <= lk_addr;
            end
            S_WB: if (bus_ack) begin
               st        <= evict ? S_FILL : S_UPDATE;
               bus_valid <= evict;
               bus_op    <= op_q == OP_WR ? BUS_RWIM : BUS_READ;
               bus_addr  <= line_addr;
            end
            S_FILL, S_BUSOP: if (bus_ack) begin
               st        <= S_UPDATE;
               bus_valid <= 1'b0;
               if (st == S_FILL) begin
                  fin_q <= fill_state;
                  tag_q <= ctag;
               end
            end
            S_UPDATE: st <= S_IDLE;
            S_CLEAR: begin
               clr_idx <= clr_idx + 1'b1;
               if (&clr_idx) st <= S_IDLE;
            end
            default: st <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/mesi_line_ctrl.md
Name: mesi_line_ctrl

Overview:
Per-line MESI controller sitting directly upstream of the MESI transition checker.
- Accepts decoded trace commands (processor and snooped), looks up a direct-mapped tag/state array and issues bus operations (writeback, read, RWIM, invalidate).
- Returns snoop results and updates the line state.
- Publishes each resulting line state as a one-cycle update for downstream checking and statistics.

Parameters:
ADDR_W, 32, address width in bits
INDEX_W, 4, set index width; NUM_SETS = 2**INDEX_W
OFFSET_W, 6, byte offset width; TAG_W = ADDR_W-INDEX_W-OFFSET_W

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_op  in  4  0 rd, 1 wr, 2 ifetch, 3 L2 invalidate, 4 snp inval, 5 snp rd, 6 snp wr, 7 snp RWIM, 8 clear, 9 print
cmd_addr  in  ADDR_W  command address
bus_valid  out  1  bus op request, held until bus_ack
bus_op  out  2  0 READ, 1 WRITE, 2 INVALIDATE, 3 RWIM
bus_addr  out  ADDR_W  line address, offset bits zero
bus_ack  in  1  bus op complete
bus_snoop_res  in  2  others' result, sampled with bus_ack: 0 NOHIT, 1 HIT, 2 HITM
upd_valid  out  1  one-cycle pulse, command finished on a set
upd_index  out  INDEX_W  set updated
upd_state  out  2  final MESI state: 0 I, 1 S, 2 E, 3 M
snoop_res_o  out  2  own snoop result, valid with upd_valid for ops 5/7, else 0

Behaviour:
- Reset:
  - FSM to IDLE; all states I; tags 0.
  - All outputs 0, except cmd_ready=1 from the first cycle after reset.
  - Reset mid-command or mid-CLEAR drops the command; bus_valid low the next cycle.
- FSM states: IDLE, LOOKUP, WB, FILL, BUSOP, UPDATE, CLEAR.
- IDLE:
  - cmd_valid&cmd_ready captures op/addr → LOOKUP.
  - Op 8 → CLEAR.
  - Op 9 or undefined: consumed, stays IDLE, no update pulse.
- LOOKUP: hit = tag match and state≠I.
- Ops 0/2 (read):
  - hit → UPDATE, state unchanged.
  - miss with victim M → WB; otherwise → FILL(READ).
  - After FILL ack, state = E if bus_snoop_res==NOHIT, else S.
- Op 1 (write):
  - hit M → M.
  - hit E → M, silent, no bus op.
  - hit S → BUSOP(INVALIDATE) → M.
  - miss → [WB if victim M] → FILL(RWIM) → M.
- Op 3 (L2 invalidate): hit M → WB → I; hit E/S → I; miss → no change.
- Op 4 (snp invalidate): hit S → I; other states unchanged.
- Op 5 (snp read):
  - M: snoop_res_o=HITM, WB, then S.
  - E/S: snoop_res_o=HIT, becomes S.
  - miss: NOHIT.
- Op 6 (snp write): no state change, snoop_res_o=NOHIT.
- Op 7 (snp RWIM):
  - M: HITM, WB, then I.
  - E/S: HIT, then I.
  - miss: NOHIT.
- Bus addresses:
  - WB: bus_op=WRITE, bus_addr = {victim tag, index, 0} for evictions, {cmd tag, index, 0} for snoop/L2 writebacks.
  - FILL: bus_addr = {cmd tag, index, 0}; tag written at FILL ack.
- Bus handshake: bus_valid/op/addr stable from state entry until the cycle bus_ack=1, inclusive; next state entered the following cycle. bus_ack outside WB/FILL/BUSOP is ignored.
- UPDATE:
  - One cycle: state array written, upd_valid=1 with index/state, → IDLE.
  - Emitted for every op 0-7, including misses and unchanged states.
- Latency (accept at cycle T): no-bus command has UPDATE at T+2, and cmd_ready returns at T+3. Each bus phase adds (cycles to ack)+1.
- CLEAR: one set per cycle from index 0 to NUM_SETS-1 (state I, tag 0); → IDLE after the last set. No upd pulses.
- cmd_ready low in every state except IDLE; cmd_valid while busy is held off.

Decomposition:
- Package mesi_pkg:
  - MESI state enum, cmd opcode enum, bus op enum, snoop result enum.
  - Default widths as localparams.
- Sub-module mesi_state_array:
  - NUM_SETS entries of {tag, state}.
  - Combinational read by index.
  - Synchronous single write port.
  - Synchronous clear-all on reset.

Test Plan:
- Reset, op0 addr 0x0000_1040, FILL ack with NOHIT → bus READ addr 0x0000_1040; upd index 1, state E.
- Same address: op1 → no bus op, upd state M at T+2. Then op0 0x0000_2040 → WB WRITE 0x0000_1040, then READ 0x0000_2040; ack with HIT → state S.
- Line S: op1 → bus INVALIDATE, upd M. Line E: op5 snooped read → snoop_res_o HIT, upd S.
- Line M: op7 → snoop_res_o HITM, WB issued, upd I. Snooped miss op5 → NOHIT, no bus op.
- Populate several sets; op8 → cmd_ready low 16 cycles, all states I. Op9 → no upd pulse.
- Assert reset while bus_valid waits for bus_ack → next cycle bus_valid 0 and cmd_ready 1; a following read of the same address misses.
